// File: rtl/pwm_multi_if.sv
// Register bus between a host and pwm_multi: one write or read strobe per cycle.
// Read data comes back one cycle after rd_en, qualified by rvalid.
interface pwm_multi_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wdata;
  logic [CNT_W-1:0]  rdata;
  logic              rvalid;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator, edge- or center-aligned, with staged
// PERIOD/DUTY registers that are copied into active shadows only at a period
// boundary or when the block is enabled.
//
// state   | meaning
// ST_IDLE | counter held at 0 (disabled or P==0), or first count after enable
// ST_UP   | counting up (edge mode always, center mode 0..P)
// ST_DOWN | center mode, counting down P-1..1
//
// Center-mode outputs are high for 2*D cycles of the 2*P period, placed
// symmetrically around the turn-around point (cnt==P).
module pwm_multi #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  pwm_multi_if.slave      bus,
  output logic [N_CH-1:0] o_pwm_out,
  output logic            o_err_irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} state_t;

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PER  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

  state_t            r_state, w_state_nxt;
  logic              r_en, r_center, r_center_act;
  logic [CNT_W-1:0]  r_per_stg, r_per_act, r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_duty_stg [N_CH];
  logic [CNT_W-1:0]  r_duty_act [N_CH];
  logic [CNT_W-1:0]  w_duty_ld  [N_CH];
  logic [N_CH-1:0]   r_err, w_over, w_w1c, w_hi, r_pwm;
  logic              r_irq, r_rvalid;
  logic [CNT_W-1:0]  r_rdata, w_rd_mux;
  logic              w_wr_ctrl, w_en_rise, w_bnd, w_load;

  assign w_wr_ctrl = bus.wr_en && (bus.addr == A_CTRL);
  assign w_en_rise = w_wr_ctrl && bus.wdata[0] && !r_en;
  assign w_load    = w_en_rise || w_bnd;
  assign w_w1c     = (bus.wr_en && (bus.addr == A_STAT)) ? N_CH'(bus.wdata) : '0;

  // Staged duty clamped to staged period; overflow flags feed ERR at load time
  always_comb begin
    w_over    = '0;
    w_duty_ld = r_duty_stg;
    for (int i = 0; i < N_CH; i++) begin
      w_over[i] = r_duty_stg[i] > r_per_stg;
      if (w_over[i]) w_duty_ld[i] = r_per_stg;
    end
  end

  // Counter next-state: direction, next count and period boundary detect
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bnd       = 1'b0;
    if (!r_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_per_act == '0) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_bnd       = 1'b1;
    end else if (r_state == ST_DOWN) begin
      if (r_cnt == ONE) begin
        w_bnd       = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_UP;
      end else begin
        w_cnt_nxt = r_cnt - ONE;
      end
    end else if (!r_center_act) begin
      w_state_nxt = ST_UP;
      if (r_cnt == r_per_act - ONE) begin
        w_bnd     = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + ONE;
      end
    end else if (r_cnt == r_per_act) begin
      if (r_per_act == ONE) begin
        // P==1 has no down leg: the peak itself closes the period
        w_bnd       = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_UP;
      end else begin
        w_cnt_nxt   = r_cnt - ONE;
        w_state_nxt = ST_DOWN;
      end
    end else begin
      w_cnt_nxt   = r_cnt + ONE;
      w_state_nxt = ST_UP;
    end
  end

  // Per-channel compare; D==P is forced high so center mode stays 100% at the peak
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_duty_act[i] == r_per_act)
        w_hi[i] = 1'b1;
      else if (!r_center_act)
        w_hi[i] = r_cnt < r_duty_act[i];
      else if (r_state == ST_DOWN)
        w_hi[i] = r_cnt >= (r_per_act - r_duty_act[i]);
      else
        w_hi[i] = r_cnt > (r_per_act - r_duty_act[i]);
    end
  end

  // Read mux over staging registers, status and control
  always_comb begin
    w_rd_mux = '0;
    case (bus.addr)
      A_CTRL: w_rd_mux = CNT_W'({r_center, r_en});
      A_PER:  w_rd_mux = r_per_stg;
      A_STAT: w_rd_mux = CNT_W'(r_err);
      default: begin
        for (int i = 0; i < N_CH; i++)
          if (bus.addr == ADDR_W'(4 + i)) w_rd_mux = r_duty_stg[i];
      end
    endcase
  end

  // Counter state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Register file, shadow loads, status, outputs and read return
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en         <= 1'b0;
      r_center     <= 1'b0;
      r_center_act <= 1'b0;
      r_per_stg    <= '0;
      r_per_act    <= '0;
      r_err        <= '0;
      r_pwm        <= '0;
      r_irq        <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_duty_stg[i] <= '0;
        r_duty_act[i] <= '0;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= bus.wdata[0];
        r_center <= bus.wdata[1];
      end
      if (bus.wr_en && (bus.addr == A_PER)) r_per_stg <= bus.wdata;
      for (int i = 0; i < N_CH; i++)
        if (bus.wr_en && (bus.addr == ADDR_W'(4 + i))) r_duty_stg[i] <= bus.wdata;

      if (w_load) begin
        r_per_act    <= r_per_stg;
        r_duty_act   <= w_duty_ld;
        // enabling picks up the mode written together with EN
        r_center_act <= w_en_rise ? bus.wdata[1] : r_center;
      end

      // hardware set wins over a same-cycle clear
      r_err <= (r_err & ~w_w1c) | (w_load ? w_over : '0);
      r_irq <= |r_err;
      r_pwm <= (r_en && (r_per_act != '0)) ? w_hi : '0;

      r_rvalid <= bus.rd_en;
      if (bus.rd_en) r_rdata <= w_rd_mux;
    end
  end

  assign o_pwm_out  = r_pwm;
  assign o_err_irq  = r_irq;
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a period-position reference model predicts every
// output each cycle; scenario tasks add fixed-value checks for the key cases.
module tb_pwm_multi;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] pwm;
  logic            irq;

  pwm_multi_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_pwm_out (pwm),
    .o_err_irq (irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // reference model: k is the position inside the current period (0..L-1)
  int              m_en = 0, m_center = 0, m_cact = 0;
  int              m_per_stg = 0, m_per_act = 0, m_k = 0, m_rdata = 0;
  int              m_dstg [N_CH] = '{default: 0};
  int              m_dact [N_CH] = '{default: 0};
  logic [N_CH-1:0] m_err = '0, m_pwm = '0;
  logic            m_irq = 1'b0, m_rvalid = 1'b0;

  function automatic bit high(int k, int p, int d, int c);
    if (d >= p) return 1'b1;
    if (c == 0) return k < d;
    return (p - d < k) && (k <= p + d);
  endfunction

  function automatic int reg_value(int a);
    if (a == 0) return m_en | (m_center << 1);
    if (a == 1) return m_per_stg;
    if (a == 2) return int'(m_err);
    if (a >= 4 && a < 4 + N_CH) return m_dstg[a-4];
    return 0;
  endfunction

  task automatic tick();
    int a, wd, len;
    int n_en, n_center, n_cact, n_per_stg, n_per_act, n_k, n_rdata;
    int n_dstg [N_CH];
    int n_dact [N_CH];
    logic [N_CH-1:0] n_err, n_pwm, set;
    logic n_irq, n_rvalid;
    bit bnd, rise;
    a = int'(bus.addr);
    wd = int'(bus.wdata);
    n_en = m_en; n_center = m_center; n_cact = m_cact;
    n_per_stg = m_per_stg; n_per_act = m_per_act; n_k = m_k; n_rdata = m_rdata;
    n_dstg = m_dstg; n_dact = m_dact; n_err = m_err;
    n_pwm = '0; n_irq = 1'b0; n_rvalid = 1'b0; set = '0;
    if (rst) begin
      n_en = 0; n_center = 0; n_cact = 0; n_per_stg = 0; n_per_act = 0;
      n_k = 0; n_rdata = 0; n_err = '0;
      n_dstg = '{default: 0};
      n_dact = '{default: 0};
    end else begin
      len  = (m_cact != 0) ? 2 * m_per_act : m_per_act;
      bnd  = (m_en != 0) && (m_per_act == 0 || m_k == len - 1);
      rise = bus.wr_en && a == 0 && (wd & 1) != 0 && m_en == 0;
      for (int i = 0; i < N_CH; i++)
        n_pwm[i] = (m_en != 0 && m_per_act != 0) && high(m_k, m_per_act, m_dact[i], m_cact);
      n_irq = |m_err;
      n_rvalid = bus.rd_en;
      if (bus.rd_en) n_rdata = reg_value(a);
      n_k = (m_en == 0 || bnd) ? 0 : m_k + 1;
      if (bnd || rise) begin
        n_per_act = m_per_stg;
        n_cact = rise ? ((wd >> 1) & 1) : m_center;
        for (int i = 0; i < N_CH; i++) begin
          n_dact[i] = (m_dstg[i] > m_per_stg) ? m_per_stg : m_dstg[i];
          set[i] = m_dstg[i] > m_per_stg;
        end
      end
      if (bus.wr_en) begin
        if (a == 0) begin
          n_en = wd & 1;
          n_center = (wd >> 1) & 1;
        end
        if (a == 1) n_per_stg = wd;
        if (a == 2) n_err = n_err & ~N_CH'(wd);
        if (a >= 4 && a < 4 + N_CH) n_dstg[a-4] = wd;
      end
      n_err = n_err | set;
    end
    @(posedge clk);
    #1;
    m_en = n_en; m_center = n_center; m_cact = n_cact;
    m_per_stg = n_per_stg; m_per_act = n_per_act; m_k = n_k; m_rdata = n_rdata;
    m_dstg = n_dstg; m_dact = n_dact; m_err = n_err;
    m_pwm = n_pwm; m_irq = n_irq; m_rvalid = n_rvalid;
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en = 1'b1;
    bus.addr  = ADDR_W'(a);
    bus.wdata = CNT_W'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input int a);
    bus.rd_en = 1'b1;
    bus.addr  = ADDR_W'(a);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    if (pwm !== '0 || irq !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs pwm=%b irq=%b rvalid=%b rdata=%0d, required all 0",
               pwm, irq, bus.rvalid, bus.rdata);
    end
    vectors++;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(a);
      if (bus.rvalid !== 1'b1 || bus.rdata !== '0) begin
        errors++;
        $display("FAIL reset_reg addr=%0d rvalid=%b rdata=%0d, required 1/0", a, bus.rvalid, bus.rdata);
      end
      vectors++;
    end
  endtask

  task automatic test_edge();
    int cnt [N_CH] = '{default: 0};
    int req [N_CH] = '{0, 3, 10, 7};
    wr(1, 10); wr(4, 0); wr(5, 3); wr(6, 10); wr(7, 7); wr(0, 1);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq || bus.rvalid !== m_rvalid) begin
        errors++;
        $display("FAIL edge_run t=%0t pwm=%b exp=%b irq=%b exp=%b rvalid=%b exp=%b",
                 $time, pwm, m_pwm, irq, m_irq, bus.rvalid, m_rvalid);
      end
      vectors++;
      if (c >= 10 && c < 20)
        for (int i = 0; i < N_CH; i++) cnt[i] += int'(pwm[i]);
    end
    for (int i = 0; i < N_CH; i++) begin
      if (cnt[i] != req[i]) begin
        errors++;
        $display("FAIL edge_duty ch=%0d high_cycles=%0d, required %0d", i, cnt[i], req[i]);
      end
      vectors++;
    end
  endtask

  task automatic test_shadow();
    int cnt = 0;
    repeat (4) tick();
    wr(5, 5);
    for (int c = 0; c < 25; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL shadow_run t=%0t pwm=%b exp=%b irq=%b exp=%b", $time, pwm, m_pwm, irq, m_irq);
      end
      vectors++;
      if (c >= 15) cnt += int'(pwm[1]);
    end
    if (cnt != 5) begin
      errors++;
      $display("FAIL shadow_new_duty ch1 high_cycles=%0d, required 5", cnt);
    end
    vectors++;
  endtask

  task automatic test_center();
    int cnt = 0;
    wr(0, 0); wr(1, 4); wr(4, 2); wr(5, 0); wr(6, 0); wr(7, 0); wr(0, 2); wr(0, 3);
    for (int c = 0; c < 24; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL center_run t=%0t pwm=%b exp=%b irq=%b exp=%b", $time, pwm, m_pwm, irq, m_irq);
      end
      vectors++;
      if (c >= 8 && c < 16) cnt += int'(pwm[0]);
    end
    if (cnt != 4) begin
      errors++;
      $display("FAIL center_duty ch0 high_cycles=%0d, required 4", cnt);
    end
    vectors++;
  endtask

  task automatic test_err();
    int cnt = 0;
    wr(0, 0); wr(2, 15); wr(1, 8); wr(6, 12); wr(0, 1);
    rd(2);
    if (bus.rdata !== CNT_W'(4) || irq !== 1'b1) begin
      errors++;
      $display("FAIL err_set status=%0d irq=%b, required 4/1", bus.rdata, irq);
    end
    vectors++;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL err_run t=%0t pwm=%b exp=%b irq=%b exp=%b", $time, pwm, m_pwm, irq, m_irq);
      end
      vectors++;
      cnt += int'(pwm[2]);
    end
    if (cnt != 8) begin
      errors++;
      $display("FAIL err_clamp ch2 high_cycles=%0d, required 8", cnt);
    end
    vectors++;
    wr(6, 3);
    repeat (10) tick();
    wr(2, 4);
    tick();
    if (irq !== 1'b0 || irq !== m_irq) begin
      errors++;
      $display("FAIL err_w1c irq=%b, required 0", irq);
    end
    vectors++;
  endtask

  task automatic test_zero_period();
    wr(0, 0); wr(1, 0); wr(4, 3); wr(0, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (pwm !== '0 || pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL zero_period pwm=%b irq=%b exp_irq=%b, required pwm 0", pwm, irq, m_irq);
      end
      vectors++;
    end
    wr(1, 6);
    tick();
    tick();
    if (pwm[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_restart ch0=%b, required 1", pwm[0]);
    end
    vectors++;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL zero_run t=%0t pwm=%b exp=%b irq=%b exp=%b", $time, pwm, m_pwm, irq, m_irq);
      end
      vectors++;
    end
    wr(0, 0); wr(2, 15);
  endtask

  task automatic test_max_period();
    int cnt = 0;
    wr(1, 255); wr(4, 128); wr(5, 255); wr(6, 1); wr(7, 0); wr(0, 1);
    for (int c = 0; c < 520; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL max_edge t=%0t pwm=%b exp=%b irq=%b exp=%b", $time, pwm, m_pwm, irq, m_irq);
      end
      vectors++;
    end
    wr(0, 0); wr(0, 2); wr(0, 3);
    for (int c = 0; c < 1030; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL max_center t=%0t pwm=%b exp=%b irq=%b exp=%b", $time, pwm, m_pwm, irq, m_irq);
      end
      vectors++;
      if (c >= 10 && c < 520) cnt += int'(pwm[0]);
    end
    if (cnt != 256) begin
      errors++;
      $display("FAIL max_center_duty ch0 high_cycles=%0d, required 256", cnt);
    end
    vectors++;
  endtask

  task automatic test_random();
    int op, a, d;
    for (int c = 0; c < 3000; c++) begin
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 15);
      if (a == 0)
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : (1 | ($urandom_range(0, 1) << 1));
      else if (a == 1)
        d = $urandom_range(0, 12);
      else
        d = $urandom_range(0, 14);
      bus.addr  = ADDR_W'(a);
      bus.wdata = CNT_W'(d);
      bus.wr_en = (op <= 2);
      bus.rd_en = (op == 3 || op == 4);
      tick();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      if (pwm !== m_pwm || irq !== m_irq || bus.rvalid !== m_rvalid ||
          (m_rvalid && bus.rdata !== CNT_W'(m_rdata))) begin
        errors++;
        $display("FAIL random t=%0t pwm=%b exp=%b irq=%b exp=%b rvalid=%b exp=%b rdata=%0d exp=%0d",
                 $time, pwm, m_pwm, irq, m_irq, bus.rvalid, m_rvalid, bus.rdata, m_rdata);
      end
      vectors++;
    end
  endtask

  task automatic test_reset_mid();
    wr(0, 0); wr(1, 10); wr(4, 4); wr(5, 9); wr(6, 0); wr(7, 10); wr(0, 1);
    for (int c = 0; c < 13; c++) begin
      tick();
      if (pwm !== m_pwm || irq !== m_irq) begin
        errors++;
        $display("FAIL pre_reset t=%0t pwm=%b exp=%b irq=%b exp=%b", $time, pwm, m_pwm, irq, m_irq);
      end
      vectors++;
    end
    rst = 1'b1;
    bus.rd_en = 1'b1;
    bus.addr  = ADDR_W'(1);
    tick();
    bus.rd_en = 1'b0;
    if (pwm !== '0 || irq !== 1'b0 || bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset pwm=%b irq=%b rvalid=%b, required 0/0/0", pwm, irq, bus.rvalid);
    end
    vectors++;
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(a);
      if (bus.rvalid !== 1'b1 || bus.rdata !== '0) begin
        errors++;
        $display("FAIL post_reset_reg addr=%0d rvalid=%b rdata=%0d, required 1/0", a, bus.rvalid, bus.rdata);
      end
      vectors++;
    end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    test_reset();
    test_edge();
    test_shadow();
    test_center();
    test_err();
    test_zero_period();
    test_max_period();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent PWM channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of counter, PERIOD and DUTY registers (4..32).
REQ-003 Parameter ADDR_W, default 4, register address width; SHALL satisfy 2**ADDR_W >= 4+N_CH.
REQ-004 clk  input  1  single clock; every flop SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-007 rd_en  input  1  register read strobe.
REQ-008 addr  input  ADDR_W  register address.
REQ-009 wdata  input  CNT_W  write data.
REQ-010 rdata  output  CNT_W  read data, valid when rvalid=1.
REQ-011 rvalid  output  1  read-data valid, one-cycle pulse.
REQ-012 pwm_out  output  N_CH  PWM outputs, registered.
REQ-013 err_irq  output  1  OR of all STATUS error bits, registered.

Function
REQ-014 Register map: 0x0 CTRL (bit0 EN, bit1 CENTER), 0x1 PERIOD, 0x2 STATUS (bits N_CH-1:0 ERR, write-1-to-clear), 0x3 reserved (reads 0), 0x4+i DUTY[i] for i in 0..N_CH-1.
REQ-015 Writes to PERIOD and DUTY SHALL go to staging registers; active (shadow) values SHALL be loaded only at a period boundary or on the EN 0->1 transition.
REQ-016 Reads SHALL return staging values for PERIOD/DUTY, with rdata/rvalid one cycle after rd_en; unmapped addresses SHALL read 0 and ignore writes.
REQ-017 Edge mode (CENTER=0): counter counts 0..P-1 and wraps to 0; boundary is the cycle where cnt==P-1.
REQ-018 Center mode (CENTER=1): counter counts up 0..P, then down P-1..1, then 0; period length 2P cycles; boundary is the cycle where the counter is 1 and counting down (or cnt==P when P==1).
REQ-019 pwm_out[i] SHALL be registered as (cnt < D[i]) using active P and D[i], so it lags the counter by one cycle.
REQ-020 D[i]==0 SHALL give constant low; D[i]==P SHALL give constant high.
REQ-021 At each shadow load, ERR[i] SHALL be set if staged DUTY[i] > staged PERIOD; the loaded active D[i] SHALL be clamped to P (100% duty).
REQ-022 Active P==0 SHALL hold the counter at 0, force all pwm_out low, and make every cycle a boundary so that new staged values load on the next cycle.
REQ-023 EN=0 SHALL hold the counter at 0 and force pwm_out to 0; EN 0->1 SHALL load shadows in that cycle and start counting from 0 on the next cycle.
REQ-024 Changing CENTER while EN=1 SHALL take effect only at the next boundary; the mode bit is shadowed like PERIOD.
REQ-025 A write to staging in the same cycle as a shadow load SHALL NOT be captured by that load; it applies at the following boundary.
REQ-026 A STATUS W1C in the same cycle as a hardware ERR set on the same bit SHALL leave the bit set.
REQ-027 Counter arithmetic SHALL be CNT_W bits with no overflow; P=2**CNT_W-1 SHALL be supported in both modes.

Reset
REQ-028 During rst=1, the following SHALL be 0: CTRL, staging PERIOD/DUTY, active P/D, mode shadow, counter, STATUS, pwm_out, err_irq, rdata, rvalid.
REQ-029 Asserting rst mid-period SHALL zero all state on the next edge; any in-flight read SHALL be dropped (no rvalid).

Verification
REQ-030 Edge mode, N_CH=4, CNT_W=8: PERIOD=10, DUTY0..3={0,3,10,7}, EN=1 -> pwm_out repeats every 10 cycles; ch0 always low, ch1 high 3 cycles, ch2 always high, ch3 high 7 cycles.
REQ-031 Center mode: PERIOD=4, DUTY0=2, EN=1 -> 8-cycle period; ch0 high for 4 cycles, centred on the count-down start.
REQ-032 Mid-period, write DUTY1=5 -> old duty is kept until the boundary, then 5 is applied from the next period with no glitch.
REQ-033 PERIOD=8, DUTY2=12 -> at the load, ERR[2]=1, err_irq=1 one cycle later, and ch2 is constant high; W1C 0x4 to STATUS -> err_irq returns to 0.
REQ-034 PERIOD=0 with EN=1 -> all outputs low and counter at 0; then write PERIOD=6 -> counting starts within 2 cycles.
REQ-035 Assert rst mid-period with a read pending -> all outputs 0 next cycle, no rvalid, and all registers read 0 after reset is released.
